// File: rtl/movegen_pkg.sv
// Shared movegen types: square and piece codes, position size, and position-load state.
package movegen_pkg;

    typedef logic [5:0] rankfile_t;
    typedef logic [3:0] piece_t;

    localparam int SQUARES = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } pos_load_state_e;

endpackage

// File: rtl/movegen_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester after ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Rotating priority search starting one past the last winner
    always_comb begin
        logic found;
        logic hit;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        hit   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c        = (int'(ptr) + k) % N;
            hit      = en & ~found & req[c];
            grant[c] = grant[c] | hit;
            idx      = hit ? IW'(c) : idx;
            found    = found | hit;
        end
    end

endmodule

// File: rtl/movegen_lookup_arbiter.sv
// Shares the position-store lookup port among NREQ movegen lanes with round-robin grants.
// Optional saturating grant/blocked counters when MOVEGEN_LOOKUP_ARB_STATS_EN is defined.
module movegen_lookup_arbiter #(
    parameter int NREQ       = 4,
    parameter int LOOKUP_LAT = 1,
    parameter int SQUARES    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_pos_valid,
    input  logic                in_pos_sop,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [6*NREQ-1:0]   req_rankfile,
    output logic [NREQ-1:0]     req_ready,
    output logic [5:0]          lookup_rankfile,
    input  logic [3:0]          lookup_piece,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [3:0]          rsp_piece,
    output logic                rsp_stale,
    output logic                pos_ready
`ifdef MOVEGEN_LOOKUP_ARB_STATS_EN
    ,
    input  logic                stat_clear,
    output logic [15:0]         stat_grants,
    output logic [15:0]         stat_blocked
`endif
);

    import movegen_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(SQUARES + 1);
    // Pipe stages up to the lookup_piece sample point; the response flops form the last stage.
    localparam int PD = LOOKUP_LAT + 1;

    pos_load_state_e          state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pos_ready_q, pos_ready_d;
    logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
    rankfile_t                lookup_rankfile_q, lookup_rankfile_d;
    logic [PD-1:0]            pipe_vld_q, pipe_vld_d;
    logic [PD-1:0][IW-1:0]    pipe_idx_q, pipe_idx_d;
    logic [PD-1:0]            pipe_stale_q, pipe_stale_d;
    logic [NREQ-1:0]          rsp_valid_q, rsp_valid_d;
    piece_t                   rsp_piece_q, rsp_piece_d;
    logic                     rsp_stale_q, rsp_stale_d;

    logic                     sop_s;
    logic                     arb_en_s;
    logic                     any_grant_s;
    logic [NREQ-1:0]          grant_s;
    logic [IW-1:0]            grant_idx_s;

    assign sop_s    = in_pos_valid & in_pos_sop;
    assign arb_en_s = pos_ready_q & ~sop_s;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (arb_en_s),
        .grant (grant_s),
        .idx   (grant_idx_s)
    );

    assign any_grant_s = |grant_s;

    // Position-load tracking from the snooped stream
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            EMPTY: begin
                if (sop_s) begin
                    state_d = LOADING;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = EMPTY;
                    cnt_d   = cnt_q;
                end
            end
            LOADING: begin
                if (sop_s) begin
                    state_d = LOADING;
                    cnt_d   = CW'(1);
                end else if (in_pos_valid) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(SQUARES - 1)) ? READY : LOADING;
                end else begin
                    state_d = LOADING;
                    cnt_d   = cnt_q;
                end
            end
            READY: begin
                if (sop_s) begin
                    state_d = LOADING;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = READY;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase
        pos_ready_d = (state_d == READY);
    end

    // Grant bookkeeping, lookup address and response pipeline next-state
    always_comb begin
        rr_ptr_d          = any_grant_s ? grant_idx_s : rr_ptr_q;
        lookup_rankfile_d = any_grant_s ? req_rankfile[int'(grant_idx_s) * 6 +: 6]
                                        : lookup_rankfile_q;
        pipe_vld_d[0]     = any_grant_s;
        pipe_idx_d[0]     = grant_idx_s;
        pipe_stale_d[0]   = 1'b0;
        // A sop beat taints every entry still travelling towards its response
        for (int j = 1; j < PD; j++) begin
            pipe_vld_d[j]   = pipe_vld_q[j-1];
            pipe_idx_d[j]   = pipe_idx_q[j-1];
            pipe_stale_d[j] = pipe_stale_q[j-1] | (sop_s & pipe_vld_q[j-1]);
        end
        rsp_valid_d = '0;
        rsp_valid_d[pipe_idx_q[PD-1]] = pipe_vld_q[PD-1];
        rsp_piece_d = pipe_vld_q[PD-1] ? lookup_piece : rsp_piece_q;
        rsp_stale_d = pipe_vld_q[PD-1] & (pipe_stale_q[PD-1] | sop_s);
    end

    // State, pointer and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= EMPTY;
            cnt_q             <= '0;
            pos_ready_q       <= 1'b0;
            rr_ptr_q          <= IW'(NREQ - 1);
            lookup_rankfile_q <= '0;
            pipe_vld_q        <= '0;
            pipe_idx_q        <= '0;
            pipe_stale_q      <= '0;
            rsp_valid_q       <= '0;
            rsp_piece_q       <= '0;
            rsp_stale_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            pos_ready_q       <= pos_ready_d;
            rr_ptr_q          <= rr_ptr_d;
            lookup_rankfile_q <= lookup_rankfile_d;
            pipe_vld_q        <= pipe_vld_d;
            pipe_idx_q        <= pipe_idx_d;
            pipe_stale_q      <= pipe_stale_d;
            rsp_valid_q       <= rsp_valid_d;
            rsp_piece_q       <= rsp_piece_d;
            rsp_stale_q       <= rsp_stale_d;
        end
    end

    assign req_ready       = grant_s;
    assign lookup_rankfile = lookup_rankfile_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_piece       = rsp_piece_q;
    assign rsp_stale       = rsp_stale_q;
    assign pos_ready       = pos_ready_q;

`ifdef MOVEGEN_LOOKUP_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_blocked_q, stat_blocked_d;

    // Saturating activity counters with synchronous clear
    always_comb begin
        stat_grants_d  = stat_grants_q;
        stat_blocked_d = stat_blocked_q;
        if (stat_clear) begin
            stat_grants_d  = 16'd0;
            stat_blocked_d = 16'd0;
        end else begin
            if (any_grant_s && (stat_grants_q != 16'hFFFF)) begin
                stat_grants_d = stat_grants_q + 16'd1;
            end else begin
                stat_grants_d = stat_grants_q;
            end
            if ((|req_valid) && !any_grant_s && (stat_blocked_q != 16'hFFFF)) begin
                stat_blocked_d = stat_blocked_q + 16'd1;
            end else begin
                stat_blocked_d = stat_blocked_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants_q  <= 16'd0;
            stat_blocked_q <= 16'd0;
        end else begin
            stat_grants_q  <= stat_grants_d;
            stat_blocked_q <= stat_blocked_d;
        end
    end

    assign stat_grants  = stat_grants_q;
    assign stat_blocked = stat_blocked_q;
`endif

endmodule

// File: doc/movegen_lookup_arbiter.md
Name: movegen_lookup_arbiter

Overview:
- Shares the single board-lookup port (`lookup_rankfile` in, `out_piece` out) of the board-position store among NREQ move-generator lanes.
- Snoops the position stream (`in_pos_valid`/`in_pos_sop`) and blocks grants while a new 64-square position is loading.
- Round-robin arbitration, one grant per cycle, fixed-latency pipelined responses routed back to the granted lane.
- Sits between the movegen lanes and the position store.

Parameters:
- NREQ, 4, number of requesting lanes (2..8)
- LOOKUP_LAT, 1, cycles from `lookup_rankfile` presented to `lookup_piece` valid at the store (0..3)
- SQUARES, 64, position beats per load

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_pos_valid  in  1  position stream beat valid (snooped)
- in_pos_sop  in  1  first beat of a position (qualified by `in_pos_valid`)
- req_valid  in  NREQ  per-lane lookup request
- req_rankfile  in  6*NREQ  per-lane square; lane i at bits [6i+5:6i]
- req_ready  out  NREQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- lookup_rankfile  out  6  registered square to position store
- lookup_piece  in  4  piece code from position store
- rsp_valid  out  NREQ  one-hot response strobe, registered
- rsp_piece  out  4  piece code, registered, shared by all lanes
- rsp_stale  out  1  response's lookup overlapped a position load
- pos_ready  out  1  a complete position is held; grants enabled

Behaviour:
- Reset values, all outputs 0; `rr_ptr` = NREQ-1, so lane 0 has first priority; load state EMPTY; beat count 0; pipeline valids 0.
- Load FSM:
  - EMPTY -> LOADING on `in_pos_valid & in_pos_sop`, count := 1.
  - LOADING: each `in_pos_valid` beat increments count; on the SQUARES-th beat -> READY.
  - `sop` in LOADING restarts, count := 1, stay LOADING.
  - `sop` in READY -> LOADING, count := 1.
  - Non-sop beats in EMPTY or READY are ignored.
  - `pos_ready` = (state == READY), registered.
- Arbitration is combinational in the cycle:
  - When `pos_ready`=1 and `in_pos_valid&in_pos_sop`=0: grant the first lane with `req_valid` set, searching from `rr_ptr`+1 modulo NREQ.
  - `req_ready` is one-hot or zero, never asserted without `req_valid`.
  - `rr_ptr` := granted index; unchanged when there is no grant.
  - A `sop` beat suppresses grants in that same cycle.
- Pipeline, grant in cycle T:
  - T+1: `lookup_rankfile` = granted square. It holds its last value when idle.
  - T+1+LOOKUP_LAT: `lookup_piece` is sampled.
  - T+2+LOOKUP_LAT: `rsp_valid[i]`=1 for one cycle, with `rsp_piece`.
  - Total request-to-response latency = LOOKUP_LAT+2. Throughput is one request per cycle.
  - Responses return in grant order.
  - The grant index and stale bit are carried in a shift register of depth LOOKUP_LAT+2.
- Stale marking: any in-flight entry (granted, response not yet issued) is marked stale if a `sop` beat is accepted. `rsp_stale` = that entry's stale bit, and 0 when no `rsp_valid` is set.
- In-flight lookups always complete. No flush.
- Simultaneous events: a grant and a `sop` in the same cycle cannot occur, since grants are suppressed on a `sop` beat. When a response exits and a new grant enters in the same cycle, both proceed.
- Reset mid-operation: all in-flight responses are dropped, no `rsp_valid` is produced, and the FSM returns to EMPTY.

Optional Feature:
- Macro `MOVEGEN_LOOKUP_ARB_STATS_EN`.
- When defined, adds outputs:
  - `stat_grants` [15:0]: saturating count of grants.
  - `stat_blocked` [15:0]: saturating count of cycles with any `req_valid` set and no grant.
  - `stat_clear` in [0]: synchronous clear of both counters.
  - Both counters are 0 on reset.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `movegen_pkg`:
  - `rankfile_t` (logic [5:0])
  - `piece_t` (logic [3:0])
  - constant `SQUARES`=64
  - enum `pos_load_state_e` {EMPTY, LOADING, READY}
- One natural sub-module: `rr_arbiter` (parameter N; inputs `req`, `ptr`, `en`; outputs one-hot `grant` and `idx`), combinational and reusable elsewhere in movegen.

Test Plan:
- Reset, then 64-beat position with `sop` on beat 1 -> `pos_ready` rises the cycle after beat 64. Any request before that sees `req_ready`=0.
- `pos_ready`=1, all four lanes request squares 0,9,18,27 continuously -> grants in order 0,1,2,3,0. With LOOKUP_LAT=1, lane 0 `rsp_valid` arrives 3 cycles after its grant with the piece stored at square 0.
- Lane 2 only, back-to-back 5 requests -> 5 grants on consecutive cycles, 5 consecutive responses in order, `rsp_stale`=0.
- Grant at T, `sop` beat at T+1 -> that response has `rsp_stale`=1. No grants while LOADING. Grants resume after 64 beats.
- `sop` at beat 30 of a load -> count restarts, and `pos_ready` rises only after 64 further beats.
- `rst_n` pulsed low with 3 lookups in flight -> no `rsp_valid` afterwards, `pos_ready`=0, and lane 0 has first priority after the next load.
